// File: rtl/mix_round_stage.sv
// rtl/mix_round_stage.sv - AES round tail (ShiftRows, MixColumns, AddRoundKey) feeding a 2-entry output FIFO
module mix_round_stage (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [127:0] in_state,
    input  logic [127:0] in_rk,
    input  logic [3:0]   in_tag,
    input  logic         in_mix_bypass,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out_state,
    output logic [3:0]   out_tag,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  beat_cnt
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Byte k sits at [127-8k -: 8]; row = k%4, column = k/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    logic [127:0] sr_state;
    logic [127:0] mc_state;
    logic [127:0] round_result;

    always_comb begin
        sr_state = shift_rows(in_state);
        mc_state = '0;
        for (int c = 0; c < 4; c++) begin
            mc_state[127 - 32 * c -: 32] = mix_col(sr_state[127 - 32 * c -: 32]);
        end
        round_result = (in_mix_bypass ? sr_state : mc_state) ^ in_rk;
    end

    logic [127:0] mem_state [2];
    logic [3:0]   mem_tag [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    // Handshake flags come from count only, so in_ready never depends on out_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_state = mem_state[rd_ptr];
    assign out_tag   = mem_tag[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mem_state[0] <= '0;
            mem_state[1] <= '0;
            mem_tag[0]   <= '0;
            mem_tag[1]   <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
            beat_cnt     <= 16'd0;
        end else begin
            if (push) begin
                mem_state[wr_ptr] <= round_result;
                mem_tag[wr_ptr]   <= in_tag;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                beat_cnt <= beat_cnt + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_round_stage.sv
// tb/tb_mix_round_stage.sv - randomized scoreboard bench for mix_round_stage
module tb_mix_round_stage;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] in_state = '0;
    logic [127:0] in_rk = '0;
    logic [3:0]   in_tag = '0;
    logic         in_mix_bypass = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] out_state;
    logic [3:0]   out_tag;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [15:0]  beat_cnt;

    mix_round_stage dut (
        .CLK(clk),
        .RST_N(rst_n),
        .in_state(in_state),
        .in_rk(in_rk),
        .in_tag(in_tag),
        .in_mix_bypass(in_mix_bypass),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_state(out_state),
        .out_tag(out_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [131:0] sb [$];
    int           mcount = 0;
    logic [15:0]  mbeat = '0;
    bit           started = 0;
    bit           rand_done = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [8:0] t;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            t = {a, 1'b0};
            a = t[8] ? (t[7:0] ^ 8'h1b) : t[7:0];
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k, input logic byp);
        logic [7:0]   a  [16];
        logic [7:0]   sr [16];
        logic [7:0]   mc [16];
        logic [7:0]   acc;
        logic [127:0] res;
        int           m [16] = '{2, 3, 1, 1, 1, 2, 3, 1, 1, 1, 2, 3, 3, 1, 1, 2};
        for (int i = 0; i < 16; i++) a[i] = s[127 - 8 * i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[4 * c + r] = a[4 * ((c + r) % 4) + r];
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(8'(m[4 * i + j]), sr[4 * c + j]);
                mc[4 * c + i] = acc;
            end
        res = '0;
        for (int i = 0; i < 16; i++)
            res[127 - 8 * i -: 8] = (byp ? sr[i] : mc[i]) ^ k[127 - 8 * i -: 8];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic scramble_inputs();
        in_state      = rnd128();
        in_rk         = rnd128();
        in_tag        = 4'($urandom);
        in_mix_bypass = 1'($urandom);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_exp(input logic [127:0] s, input logic [127:0] k, input logic [3:0] t,
                            input logic b, input logic [127:0] exp);
        bit done;
        done          = 0;
        in_state      = s;
        in_rk         = k;
        in_tag        = t;
        in_mix_bypass = b;
        in_valid      = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (in_ready) begin
                sb.push_back({exp, t});
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready stuck low expected acceptance tag %h", t);
        end
        in_valid = 1'b0;
        scramble_inputs();
    endtask

    task automatic send(input logic [127:0] s, input logic [127:0] k, input logic [3:0] t, input logic b);
        send_exp(s, k, t, b, ref_round(s, k, b));
    endtask

    task automatic rand_beat();
        logic [127:0] s, k;
        s = rnd128();
        k = rnd128();
        send(s, k, 4'($urandom), 1'($urandom));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            scramble_inputs();
            @(negedge clk);
        end
    endtask

    task automatic drain();
        bit done;
        done = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (sb.size() == 0) done = 1;
            else @(negedge clk);
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", sb.size());
        end
    endtask

    // Reset with a live push/pop request on the same edge; reset must win.
    task automatic do_reset();
        scramble_inputs();
        in_valid  = 1'b1;
        out_ready = 1'($urandom);
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin : monitor
        bit push, pop;
        forever begin
            @(negedge clk);
            #1;
            if (started) begin
                chk("in_ready", in_ready, mcount < 2);
                chk("out_valid", out_valid, mcount != 0);
                chk("beat_cnt", beat_cnt, mbeat);
                if (out_valid) begin
                    if (sb.size() == 0) chk("spurious_out_valid", out_valid, 0);
                    else begin
                        chk("out_state", out_state, sb[0][131:4]);
                        chk("out_tag", out_tag, sb[0][3:0]);
                    end
                end
            end
            if (!rst_n) begin
                mcount  = 0;
                mbeat   = '0;
                sb.delete();
                started = 1;
            end else if (started) begin
                push = in_valid && (mcount < 2);
                pop  = (mcount != 0) && out_ready;
                if (pop) begin
                    if (sb.size() != 0) void'(sb.pop_front());
                    mbeat = mbeat + 16'd1;
                end
                mcount = mcount + int'(push) - int'(pop);
            end
        end
    end

    initial begin : stimulus
        int c0;
        scramble_inputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_state", out_state, 0);
        chk("reset_out_tag", out_tag, 0);
        chk("reset_beat_cnt", beat_cnt, 0);

        send_exp(128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605, 4'h5, 1'b0,
                 128'ha49c7ff2689f352b6b5bea43026a5049);
        chk("fips_latency_valid", out_valid, 1);
        chk("fips_state", out_state, 128'ha49c7ff2689f352b6b5bea43026a5049);
        send_exp(128'hd42711aee0bf98f1b8b45de51e415230, 128'h0, 4'h6, 1'b1,
                 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        drain();
        idle(2);
        chk("bypass_beat_cnt", beat_cnt, 2);

        out_ready = 1'b0;
        fork
            begin
                send(rnd128(), rnd128(), 4'd1, 1'b0);
                send(rnd128(), rnd128(), 4'd2, 1'b0);
                send(rnd128(), rnd128(), 4'd3, 1'b1);
            end
            begin
                repeat (2) @(negedge clk);
                chk("bp_in_ready_third", in_ready, 0);
                @(negedge clk);
                chk("bp_in_ready_held", in_ready, 0);
                chk("bp_head_tag", out_tag, 4'd1);
                out_ready = 1'b1;
            end
        join
        drain();
        idle(2);

        do_reset();
        out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 100; i++) rand_beat();
        chk("stream_cycles", cyc - c0, 100);
        drain();
        idle(2);
        chk("stream_beat_cnt", beat_cnt, 100);

        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    rand_beat();
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(0, 9) < 6);
                    @(negedge clk);
                end
            end
        join
        drain();
        idle(2);

        out_ready = 1'b0;
        rand_beat();
        rand_beat();
        chk("stall_full_in_ready", in_ready, 0);
        do_reset();
        chk("midstall_out_valid", out_valid, 0);
        chk("midstall_in_ready", in_ready, 1);
        chk("midstall_beat_cnt", beat_cnt, 0);
        out_ready = 1'b1;
        idle(4);

        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 65537; i++) rand_beat();
        drain();
        idle(2);
        chk("wrap_beat_cnt", beat_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
